// File: rtl/io_tick_pkg.sv
// Shared register map and bit positions for the io_tick_timer block.
package io_tick_pkg;

    localparam logic [3:0] REG_COUNT    = 4'd0;
    localparam logic [3:0] REG_PRESCALE = 4'd1;
    localparam logic [3:0] REG_CTRL     = 4'd2;
    localparam logic [3:0] REG_STATUS   = 4'd3;
    localparam logic [3:0] REG_CMP0     = 4'd4;

    localparam int unsigned CTRL_EN         = 0;
    localparam int unsigned CTRL_OVF_IE     = 1;
    localparam int unsigned CTRL_CMP_IE_LSB = 2;

    localparam int unsigned ST_OVF     = 0;
    localparam int unsigned ST_CMP_LSB = 1;

endpackage

// File: rtl/io_tick_timer_if.sv
// J1 I/O bus as seen by one peripheral: strobes, address, write data and read data.
interface io_tick_timer_if;

    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    modport master (output io_rd, output io_wr, output io_addr, output io_dout, input io_din);
    modport slave  (input io_rd, input io_wr, input io_addr, input io_dout, output io_din);

endinterface

// File: rtl/io_tick_prescaler.sv
// Down-counting prescaler: emits inc when pcnt reaches zero, then reloads from load_val.
module io_tick_prescaler #(
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             en,
    input  logic             load,
    input  logic [PSC_W-1:0] load_val,
    output logic             inc
);

    logic [PSC_W-1:0] pcnt_q, pcnt_d;

    assign inc = en && (pcnt_q == '0);

    // load_val carries the live PRESCALE value, so it also serves as the reload value.
    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = load_val;
        end else if (en) begin
            pcnt_d = inc ? load_val : pcnt_q - PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/io_tick_timer.sv
// Prescaled tick counter with compare channels, W1C pending flags and a masked level irq.
module io_tick_timer
    import io_tick_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CH      = 2,
    parameter int unsigned PSC_W   = 16,
    parameter int unsigned SEL_BIT = 14
) (
    input  logic            clk,
    input  logic            resetq,
    io_tick_timer_if.slave  bus,
    output logic            irq,
    output logic            tick
);

    logic       sel, wr;
    logic [3:0] idx;
    logic       wr_count, wr_psc, wr_ctrl, wr_status;
    logic [CH-1:0] wr_cmp;

    logic [WIDTH-1:0] count_q, count_d, count_next;
    logic [PSC_W-1:0] prescale_q, psc_val;
    logic             en_q, ovf_ie_q;
    logic [CH-1:0]    cmp_ie_q;
    logic [WIDTH-1:0] cmp_q [CH];
    logic [CH:0]      pend_q, pend_d, pend_set, pend_clr;
    logic             irq_q, irq_d, tick_q, tick_d;
    logic             inc;
    logic [15:0]      rdata;
    logic             unused_bits;

    assign sel       = bus.io_addr[SEL_BIT];
    assign wr        = bus.io_wr & sel;
    assign idx       = bus.io_addr[3:0];
    assign wr_count  = wr && (idx == REG_COUNT);
    assign wr_psc    = wr && (idx == REG_PRESCALE);
    assign wr_ctrl   = wr && (idx == REG_CTRL);
    assign wr_status = wr && (idx == REG_STATUS);

    always_comb begin
        wr_cmp = '0;
        for (int n = 0; n < CH; n++) begin
            wr_cmp[n] = wr && (idx == 4'(int'(REG_CMP0) + n));
        end
    end

    // A PRESCALE write reloads pcnt with the new value on the same edge.
    assign psc_val = wr_psc ? bus.io_dout[PSC_W-1:0] : prescale_q;

    io_tick_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk      (clk),
        .resetq   (resetq),
        .en       (en_q),
        .load     (wr_psc),
        .load_val (psc_val),
        .inc      (inc)
    );

    // Compare matches use the old CMPn; a COUNT write suppresses the increment and all flags.
    always_comb begin
        count_next = count_q + WIDTH'(1);
        pend_set   = '0;
        if (inc && !wr_count) begin
            pend_set[ST_OVF] = &count_q;
            for (int n = 0; n < CH; n++) begin
                pend_set[ST_CMP_LSB + n] = (count_next == cmp_q[n]);
            end
        end
        count_d  = wr_count ? bus.io_dout[WIDTH-1:0] : (inc ? count_next : count_q);
        pend_clr = wr_status ? bus.io_dout[CH:0] : '0;
        pend_d   = (pend_q & ~pend_clr) | pend_set;
        irq_d    = |(pend_q & {cmp_ie_q, ovf_ie_q});
        tick_d   = inc && !wr_count;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            count_q    <= '0;
            prescale_q <= '0;
            en_q       <= 1'b1;
            ovf_ie_q   <= 1'b0;
            cmp_ie_q   <= '0;
            pend_q     <= '0;
            irq_q      <= 1'b0;
            tick_q     <= 1'b0;
            for (int n = 0; n < CH; n++) begin
                cmp_q[n] <= '0;
            end
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
            tick_q  <= tick_d;
            if (wr_psc) begin
                prescale_q <= bus.io_dout[PSC_W-1:0];
            end
            if (wr_ctrl) begin
                en_q     <= bus.io_dout[CTRL_EN];
                ovf_ie_q <= bus.io_dout[CTRL_OVF_IE];
                cmp_ie_q <= bus.io_dout[CTRL_CMP_IE_LSB +: CH];
            end
            for (int n = 0; n < CH; n++) begin
                if (wr_cmp[n]) begin
                    cmp_q[n] <= bus.io_dout[WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (idx)
                REG_COUNT:    rdata[WIDTH-1:0] = count_q;
                REG_PRESCALE: rdata[PSC_W-1:0] = prescale_q;
                REG_CTRL: begin
                    rdata[CTRL_EN]                 = en_q;
                    rdata[CTRL_OVF_IE]             = ovf_ie_q;
                    rdata[CTRL_CMP_IE_LSB +: CH]   = cmp_ie_q;
                end
                REG_STATUS:   rdata[CH:0] = pend_q;
                default: begin
                    for (int n = 0; n < CH; n++) begin
                        if (idx == 4'(int'(REG_CMP0) + n)) begin
                            rdata[WIDTH-1:0] = cmp_q[n];
                        end
                    end
                end
            endcase
        end
    end

    assign bus.io_din = rdata;
    assign irq        = irq_q;
    assign tick       = tick_q;

    // io_rd and the undecoded address/data bits have no function here.
    assign unused_bits = ^{bus.io_rd, bus.io_addr, bus.io_dout};

endmodule

// File: tb/tb_io_tick_timer.sv
// Directed bench for io_tick_timer with a per-cycle reference model and literal spot checks.
module tb_io_tick_timer;

    localparam int          CH  = 2;
    localparam logic [15:0] SEL = 16'h4000;

    logic clk = 1'b0;
    logic resetq = 1'b0;
    logic irq, tick;
    int   checks = 0;
    int   failures = 0;

    io_tick_timer_if bus();

    io_tick_timer #(
        .WIDTH   (16),
        .CH      (CH),
        .PSC_W   (16),
        .SEL_BIT (14)
    ) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus),
        .irq    (irq),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    // Reference model: register contents as plain integers.
    int m_count, m_psc, m_pcnt, m_ctrl, m_pend;
    int m_cmp [CH];
    bit m_irq, m_tick;

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_read(input logic [15:0] a);
        int i;
        if (!a[14]) return 0;
        i = int'(a[3:0]);
        if (i == 0) return m_count;
        if (i == 1) return m_psc;
        if (i == 2) return m_ctrl;
        if (i == 3) return m_pend;
        if (i >= 4 && i < 4 + CH) return m_cmp[i-4];
        return 0;
    endfunction

    always @(posedge clk or negedge resetq) begin : model
        int  i, d, nc, np, set, clr;
        bit  w, en, inc, cw;
        if (!resetq) begin
            m_count <= 0;
            m_psc   <= 0;
            m_pcnt  <= 0;
            m_ctrl  <= 1;
            m_pend  <= 0;
            m_irq   <= 1'b0;
            m_tick  <= 1'b0;
            for (int n = 0; n < CH; n++) m_cmp[n] <= 0;
        end else begin
            w   = bus.io_wr && bus.io_addr[14];
            i   = int'(bus.io_addr[3:0]);
            d   = int'(bus.io_dout);
            en  = (m_ctrl & 1) != 0;
            inc = en && (m_pcnt == 0);
            cw  = w && (i == 0);
            set = 0;
            nc  = m_count;
            if (cw) begin
                nc = d;
            end else if (inc) begin
                nc = (m_count + 1) % 65536;
                if (m_count == 65535) set = set | 1;
                for (int n = 0; n < CH; n++) if (nc == m_cmp[n]) set = set | (1 << (n + 1));
            end
            if (w && i == 1) np = d;
            else if (en)     np = (m_pcnt == 0) ? m_psc : m_pcnt - 1;
            else             np = m_pcnt;
            clr = (w && i == 3) ? d : 0;
            m_irq   <= (m_pend & (m_ctrl >> 1)) != 0;
            m_tick  <= inc && !cw;
            m_count <= nc;
            m_pcnt  <= np;
            m_pend  <= ((m_pend & ~clr) | set) & ((1 << (CH + 1)) - 1);
            if (w && i == 1) m_psc <= d;
            if (w && i == 2) m_ctrl <= d & ((1 << (2 + CH)) - 1);
            for (int n = 0; n < CH; n++) if (w && i == 4 + n) m_cmp[n] <= d;
        end
    end

    always @(negedge clk) begin
        lit("model_din", bus.io_din, 16'(m_read(bus.io_addr)));
        lit("model_irq", {15'b0, irq}, {15'b0, m_irq});
        lit("model_tick", {15'b0, tick}, {15'b0, m_tick});
    end

    task automatic wr(input logic [3:0] idx, input logic [15:0] d);
        bus.io_addr = SEL | {12'b0, idx};
        bus.io_dout = d;
        bus.io_wr   = 1'b1;
        @(posedge clk);
        #1;
        bus.io_wr   = 1'b0;
    endtask

    task automatic chk(input logic [3:0] idx, input logic [15:0] exp, input logic exp_irq,
                       input string name);
        bus.io_addr = SEL | {12'b0, idx};
        bus.io_rd   = 1'b1;
        @(negedge clk);
        lit({name, "_din"}, bus.io_din, exp);
        lit({name, "_irq"}, {15'b0, irq}, {15'b0, exp_irq});
        @(posedge clk);
        #1;
        bus.io_rd   = 1'b0;
    endtask

    initial begin
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        bus.io_addr = SEL;
        bus.io_dout = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        resetq = 1'b1;

        // Defaults: one increment per cycle.
        for (int i = 0; i < 4; i++) chk(4'd0, 16'(i), 1'b0, "free_count");
        @(negedge clk);
        lit("free_tick", {15'b0, tick}, 16'h0001);
        @(posedge clk);
        #1;
        chk(4'd2, 16'h0001, 1'b0, "ctrl_reset");

        // PRESCALE=3: one increment every 4 cycles; CTRL=0 freezes.
        wr(4'd1, 16'd3);
        wr(4'd0, 16'd0);
        for (int i = 0; i < 8; i++) chk(4'd0, 16'((i + 1) / 4), 1'b0, "psc3_count");
        wr(4'd2, 16'h0000);
        for (int i = 0; i < 3; i++) chk(4'd0, 16'd2, 1'b0, "frozen_count");

        // Overflow with OVF_IE, then W1C.
        wr(4'd4, 16'h8000);
        wr(4'd5, 16'h8001);
        wr(4'd1, 16'd0);
        wr(4'd0, 16'hFFFE);
        wr(4'd2, 16'h0003);
        chk(4'd0, 16'hFFFE, 1'b0, "ovf_pre0");
        chk(4'd0, 16'hFFFF, 1'b0, "ovf_pre1");
        chk(4'd3, 16'h0001, 1'b0, "ovf_flag");
        chk(4'd3, 16'h0001, 1'b1, "ovf_irq");
        wr(4'd3, 16'h0001);
        chk(4'd3, 16'h0000, 1'b1, "ovf_clr");
        chk(4'd3, 16'h0000, 1'b0, "ovf_irq_low");

        // Compare channel 1 with CMP1_IE; a direct COUNT write sets nothing.
        wr(4'd2, 16'h0000);
        wr(4'd5, 16'h0010);
        wr(4'd1, 16'd0);
        wr(4'd0, 16'h000E);
        wr(4'd2, 16'h0009);
        chk(4'd0, 16'h000E, 1'b0, "cmp_pre0");
        chk(4'd0, 16'h000F, 1'b0, "cmp_pre1");
        chk(4'd3, 16'h0004, 1'b0, "cmp_flag");
        chk(4'd3, 16'h0004, 1'b1, "cmp_irq");
        wr(4'd3, 16'hFFFF);
        wr(4'd2, 16'h0008);
        wr(4'd0, 16'h0010);
        chk(4'd3, 16'h0000, 1'b0, "cmp_direct_write");
        chk(4'd0, 16'h0010, 1'b0, "cmp_direct_count");

        // W1C racing an overflow: set wins.
        wr(4'd0, 16'hFFFF);
        wr(4'd2, 16'h0001);
        wr(4'd3, 16'h0001);
        chk(4'd3, 16'h0001, 1'b0, "w1c_vs_set");
        wr(4'd3, 16'h0001);
        // COUNT write racing an increment from all-ones: write wins, no OVF.
        wr(4'd2, 16'h0000);
        wr(4'd0, 16'hFFFF);
        wr(4'd2, 16'h0001);
        wr(4'd0, 16'h1234);
        chk(4'd0, 16'h1234, 1'b0, "wr_vs_inc_count");
        chk(4'd3, 16'h0000, 1'b0, "wr_vs_inc_status");

        // Asynchronous reset with irq and pending active.
        wr(4'd2, 16'h0003);
        wr(4'd0, 16'hFFFF);
        chk(4'd0, 16'hFFFF, 1'b0, "rst_pre0");
        chk(4'd3, 16'h0001, 1'b0, "rst_pre1");
        chk(4'd3, 16'h0001, 1'b1, "rst_pre2");
        resetq = 1'b0;
        #1;
        lit("rst_status", bus.io_din, 16'h0000);
        lit("rst_irq", {15'b0, irq}, 16'h0000);
        lit("rst_tick", {15'b0, tick}, 16'h0000);
        bus.io_addr = SEL | 16'h0000;
        #1;
        lit("rst_count", bus.io_din, 16'h0000);
        bus.io_addr = SEL | 16'h0002;
        #1;
        lit("rst_ctrl", bus.io_din, 16'h0001);
        @(posedge clk);
        #1;
        resetq = 1'b1;
        chk(4'd0, 16'h0000, 1'b0, "post_rst0");
        chk(4'd0, 16'h0001, 1'b0, "post_rst1");

        // Not selected, and unmapped index.
        bus.io_addr = 16'h0000;
        #1;
        lit("unsel_count", bus.io_din, 16'h0000);
        bus.io_addr = 16'h0002;
        #1;
        lit("unsel_ctrl", bus.io_din, 16'h0000);
        @(posedge clk);
        #1;
        chk(4'hF, 16'h0000, 1'b0, "unmapped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_tick_timer.md
Name: io_tick_timer

Overview:
- Parametrised successor to the single free-running ticks counter on the J1 I/O bus.
- Adds a programmable prescaler, an enable control, CH compare channels and overflow/compare pending flags.
- Pending flags are write-1-to-clear; the interrupt request is masked and level-sensitive.
- Sits beside the GPIO/UART decode in the SoC top; its io_din contribution is OR-combined with the other peripherals, and irq drives the CPU's interrupt_request.

Parameters:
- WIDTH, 16: counter and compare width, 1..16; reads are zero-extended to 16 bits.
- CH, 2: number of compare channels, 1..8.
- PSC_W, 16: prescaler width, 1..16.
- SEL_BIT, 14: io_addr bit that selects this block.

Ports:
- clk  in  1  system clock; single clock domain.
- resetq  in  1  asynchronous active-low reset.
- io_rd  in  1  CPU I/O read strobe.
- io_wr  in  1  CPU I/O write strobe.
- io_addr  in  16  I/O address; bit SEL_BIT selects the block, [3:0] is the register index.
- io_dout  in  16  CPU write data.
- io_din  out  16  read data; 0 when the block is not selected.
- irq  out  1  registered interrupt request, level.
- tick  out  1  registered one-cycle pulse on each counter increment.

Behaviour:
- sel = io_addr[SEL_BIT]; a write is wr = io_wr & sel. Reads are combinational and have no side effects.
- Register map by io_addr[3:0]:
  - 0 COUNT: R/W.
  - 1 PRESCALE: R/W.
  - 2 CTRL: bit0 EN, bit1 OVF_IE, bits[2+CH-1:2] CMP_IE.
  - 3 STATUS: read gives pending (bit0 OVF, bits[CH:1] CMPn); a write clears every bit written as 1.
  - 4..4+CH-1 CMPn: R/W.
  - Unmapped indices read 0 and ignore writes. Unused high bits read 0.
- Reset values: COUNT=0, PRESCALE=0, pcnt=0, CTRL=0x0001 (counting enabled, interrupts off), CMPn=0, pending=0, irq=0, tick=0.
- Prescaler:
  - When EN=1: if pcnt==0, an increment event occurs and pcnt reloads PRESCALE; otherwise pcnt decrements.
  - PRESCALE=0 gives one increment per cycle; PRESCALE=N gives one increment every N+1 cycles.
  - EN=0 freezes both pcnt and COUNT.
  - Writing PRESCALE also loads pcnt with the new value in the same edge.
- Increment event:
  - COUNT <= COUNT+1, modulo 2^WIDTH.
  - tick=1 on the next cycle.
  - If the old COUNT was all-ones, pending OVF is set.
  - For each n, if the new COUNT == CMPn, pending CMPn is set.
- COUNT write: takes priority over an increment in the same cycle. It sets no flags, even if the written value equals a CMPn or the overflow would otherwise have occurred.
- Pending set and W1C clear on the same bit in the same cycle: set wins.
- CMPn write in the same cycle as a match uses the old CMPn value.
- irq <= |(pending & {CMP_IE, OVF_IE}), registered, so it has 1-cycle latency from the flag update.
  - irq stays high until flags are cleared or masked.
  - Clearing CTRL interrupt-enable bits drops irq on the next edge.
- Reset asserted mid-count: all state returns to reset values immediately and asynchronously. Counting resumes on the first edge after deassertion.
- io_rd is accepted but unused; the read path is purely combinational.

Decomposition:
- Package io_tick_pkg:
  - register index constants REG_COUNT, REG_PRESCALE, REG_CTRL, REG_STATUS, REG_CMP0.
  - CTRL bit positions CTRL_EN, CTRL_OVF_IE, CTRL_CMP_IE_LSB.
  - STATUS bit positions ST_OVF, ST_CMP_LSB.
- Sub-module io_tick_prescaler (clk, resetq, en, load, load_val, inc): contains the pcnt down-counter and its reload logic.
- The top handles the register file, compare bank, pending/irq logic and read mux.

Test Plan:
- After reset with defaults, no writes: COUNT reads 0,1,2,… on consecutive cycles; tick high every cycle; irq=0; CTRL reads 0x0001.
- PRESCALE=3, then COUNT=0: COUNT increments once every 4 cycles; tick pulses with period 4; CTRL=0 freezes COUNT.
- COUNT=0xFFFE, CTRL=0x0003: after 2 increments COUNT=0x0000, STATUS=0x0001, irq high one cycle later. Write STATUS=0x0001 → STATUS=0, irq low the next cycle.
- CMP1=0x0010, CTRL enables CMP1_IE, COUNT=0x000E: STATUS bit2 sets when COUNT becomes 0x0010. Writing COUNT=0x0010 directly sets no flag.
- W1C of STATUS bit0 in the same cycle as an overflow: bit0 remains 1. COUNT write in the same cycle as an increment from 0xFFFF: written value kept, OVF not set.
- Assert resetq low mid-count with pending flags set: all registers, irq and tick go to reset values without a clock edge. io_din=0 whenever io_addr[14]=0.
